// File: rtl/dmem_access_unit.sv
// MEM-stage data-access unit: handshaked variable-latency RAM access with lane alignment and load extension.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses trap for one cycle instead of rounding down.
module dmem_access_unit (
    input  logic        clk,
    input  logic        rstn,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        stall_o,
    output logic [31:0] Data_read_o,
    output logic        misalign_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ready_i,
    input  logic [31:0] dmem_rdata_i
);

    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
`ifdef MISALIGN_TRAP_EN
        , S_ERR
`endif
    } state_t;

    state_t          state;
    logic [2:0]      lat_f3;
    logic [1:0]      lat_off;
    logic            access_c;
    logic            is_store_c;
    logic [BW-1:0]   be_c;
    logic [DW-1:0]   wdata_c;

    assign access_c   = MemRead_in || MemWrite_in;
    assign is_store_c = MemWrite_in;

    // Stall is combinational so the instruction is held in the same cycle it arrives.
    assign stall_o = rstn && (((state == S_IDLE) && access_c) || (state == S_REQ));

    // Store lane enables and lane-replicated data; loads always read the whole word.
    always_comb begin
        be_c    = {BW{1'b1}};
        wdata_c = wdata_in;
        if (is_store_c) begin
            case (funct3_in)
                3'b000: begin
                    be_c    = BW'(4'b0001 << addr_in[1:0]);
                    wdata_c = {4{wdata_in[7:0]}};
                end
                3'b001: begin
                    be_c    = addr_in[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{wdata_in[15:0]}};
                end
                default: ;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic half_c;
    logic misalign_c;
    assign half_c     = (funct3_in == 3'b001) || (!is_store_c && (funct3_in == 3'b101));
    assign misalign_c = (half_c && addr_in[0]) ||
                        ((funct3_in == 3'b010) && (addr_in[1:0] != 2'b00));
`else
    assign misalign_o = 1'b0;
`endif

    // Byte/half selection by offset, then sign or zero extension.
    function automatic logic [DW-1:0] load_extend(input logic [2:0] f3,
                                                  input logic [1:0] off,
                                                  input logic [DW-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b100:  load_extend = {24'h000000, b};
            3'b101:  load_extend = {16'h0000, h};
            default: load_extend = w;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            lat_f3       <= 3'b000;
            lat_off      <= 2'b00;
            Data_read_o  <= '0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign_o   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (access_c) begin
`ifdef MISALIGN_TRAP_EN
                        if (misalign_c) begin
                            misalign_o <= 1'b1;
                            state      <= S_ERR;
                        end else
`endif
                        begin
                            lat_f3       <= funct3_in;
                            lat_off      <= addr_in[1:0];
                            dmem_we_o    <= is_store_c;
                            dmem_addr_o  <= {addr_in[31:2], 2'b00};
                            dmem_be_o    <= be_c;
                            dmem_wdata_o <= wdata_c;
                            dmem_req_o   <= 1'b1;
                            state        <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_ready_i) begin
                        dmem_req_o <= 1'b0;
                        if (!dmem_we_o) begin
                            Data_read_o <= load_extend(lat_f3, lat_off, dmem_rdata_i);
                        end
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
`ifdef MISALIGN_TRAP_EN
                S_ERR: begin
                    misalign_o <= 1'b0;
                    state      <= S_IDLE;
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed scenarios plus random accesses against a word-array RAM model.
// Honours MISALIGN_TRAP_EN the same way as the design.
module tb_dmem_access_unit;

    logic        clk;
    logic        rstn;
    logic        MemRead_in;
    logic        MemWrite_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        stall_o;
    logic [31:0] Data_read_o;
    logic        misalign_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ready_i;
    logic [31:0] dmem_rdata_i;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_dr;

    dmem_access_unit dut (
        .clk          (clk),
        .rstn         (rstn),
        .MemRead_in   (MemRead_in),
        .MemWrite_in  (MemWrite_in),
        .funct3_in    (funct3_in),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .stall_o      (stall_o),
        .Data_read_o  (Data_read_o),
        .misalign_o   (misalign_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ready_i (dmem_ready_i),
        .dmem_rdata_i (dmem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] wa);
        if (!mem.exists(wa)) mem[wa] = {wa[15:0] ^ 16'hA5C3, ~wa[15:0]};
        return mem[wa];
    endfunction

    // Reference load result from the load rules, using plain shifts and arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic idle_inputs();
        MemRead_in   = 1'b0;
        MemWrite_in  = 1'b0;
        funct3_in    = 3'($urandom);
        addr_in      = $urandom;
        wdata_in     = $urandom;
        dmem_ready_i = 1'($urandom);
        dmem_rdata_i = $urandom;
    endtask

    // One instruction in the MEM stage; called at posedge+1 with the FSM in IDLE.
    task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int waits);
        int          off;
        logic [31:0] wa;
        logic [3:0]  be;
        logic [31:0] wdr;
        logic [31:0] word;
        bit          st;
        bit          half;
        bit          mis;
        int          stalls;
        st   = wr;
        off  = int'(a % 4);
        wa   = a - (a % 4);
        be   = 4'hF;
        wdr  = wd;
        if (st && f3 == 3'd0) begin
            be  = 4'(1 << off);
            wdr = (wd & 32'hFF) * 32'h01010101;
        end else if (st && f3 == 3'd1) begin
            be  = 4'(3 << (off - off % 2));
            wdr = (wd & 32'hFFFF) * 32'h00010001;
        end
        half = st ? (f3 == 3'd1) : (f3 == 3'd1 || f3 == 3'd5);
        mis  = (half && (off % 2 != 0)) || (f3 == 3'd2 && off != 0);
        MemRead_in   = rd;
        MemWrite_in  = wr;
        funct3_in    = f3;
        addr_in      = a;
        wdata_in     = wd;
        dmem_ready_i = 1'($urandom);
        dmem_rdata_i = $urandom;
        #1;
        if (!(rd || wr)) begin
            check("nomem_stall", 32'(stall_o), 32'd0);
            check("nomem_req", 32'(dmem_req_o), 32'd0);
            @(posedge clk); #1;
            return;
        end
        check("idle_stall", 32'(stall_o), 32'd1);
        stalls = int'(stall_o);
`ifdef MISALIGN_TRAP_EN
        if (mis) begin
            @(posedge clk); #1;
            check("err_misalign", 32'(misalign_o), 32'd1);
            check("err_stall", 32'(stall_o), 32'd0);
            check("err_req", 32'(dmem_req_o), 32'd0);
            check("err_data", Data_read_o, exp_dr);
            idle_inputs();
            @(posedge clk); #1;
            check("err_done", 32'(misalign_o), 32'd0);
            return;
        end
`else
        if (mis) check("nomis_pulse", 32'(misalign_o), 32'd0);
`endif
        @(posedge clk); #1;
        word = mem_rd(wa);
        for (int c = 0; c <= waits; c++) begin
            check("req_req", 32'(dmem_req_o), 32'd1);
            check("req_we", 32'(dmem_we_o), 32'(st));
            check("req_addr", dmem_addr_o, wa);
            check("req_be", 32'(dmem_be_o), 32'(be));
            if (st) check("req_wdata", dmem_wdata_o, wdr);
            stalls += int'(stall_o);
            dmem_ready_i = (c == waits);
            dmem_rdata_i = (c == waits) ? word : $urandom;
            @(posedge clk); #1;
        end
        check("resp_req", 32'(dmem_req_o), 32'd0);
        check("resp_stall", 32'(stall_o), 32'd0);
        check("stall_cycles", 32'(stalls), 32'(2 + waits));
        if (!st) exp_dr = ref_load(f3, off, word);
        check("resp_data", Data_read_o, exp_dr);
        if (st) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) word[8*i +: 8] = wdr[8*i +: 8];
            mem[wa] = word;
        end
        dmem_ready_i = 1'($urandom);
        dmem_rdata_i = $urandom;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2:0] ld_f3 [5];
        logic [31:0] sw_val;
        int kind;
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        exp_dr = 32'h0;
        rstn = 1'b0;
        idle_inputs();
        MemRead_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_req", 32'(dmem_req_o), 32'd0);
        check("rst_data", Data_read_o, 32'd0);
        check("rst_misalign", 32'(misalign_o), 32'd0);
        check("rst_addr", dmem_addr_o, 32'd0);
        check("rst_be", 32'(dmem_be_o), 32'd0);
        check("rst_wdata", dmem_wdata_o, 32'd0);
        check("rst_we", 32'(dmem_we_o), 32'd0);
        idle_inputs();
        rstn = 1'b1;
        @(posedge clk); #1;

        access(1'b0, 1'b1, 3'd0, 32'h0000_1003, 32'h0000_00AB, 0);
        check("tp_sb_word", mem[32'h1000] & 32'hFF00_0000, 32'hAB00_0000);

        mem[32'h2000] = 32'h12F4_5678;
        access(1'b1, 1'b0, 3'd0, 32'h0000_2002, 32'h0, 0);
        check("tp_lb", Data_read_o, 32'hFFFF_FFF4);
        access(1'b1, 1'b0, 3'd4, 32'h0000_2002, 32'h0, 1);
        check("tp_lbu", Data_read_o, 32'h0000_00F4);
        access(1'b1, 1'b0, 3'd5, 32'h0000_2002, 32'h0, 0);
        check("tp_lhu", Data_read_o, 32'h0000_12F4);
        access(1'b0, 1'b1, 3'd0, 32'h0000_2001, 32'h0000_0099, 2);
        check("tp_hold_store", Data_read_o, 32'h0000_12F4);

        access(1'b1, 1'b0, 3'd2, 32'h0000_2000, 32'h0, 3);
        check("tp_lw_wait", Data_read_o, 32'h12F4_9978);

        sw_val = $urandom;
        access(1'b0, 1'b1, 3'd2, 32'h0000_3000, sw_val, 0);
        access(1'b1, 1'b0, 3'd2, 32'h0000_3000, 32'h0, 0);
        check("tp_sw_lw", Data_read_o, sw_val);

        // Reset in the middle of a waiting read.
        MemRead_in   = 1'b1;
        MemWrite_in  = 1'b0;
        funct3_in    = 3'd2;
        addr_in      = 32'h0000_3000;
        dmem_ready_i = 1'b0;
        @(posedge clk); #1;
        check("mid_req", 32'(dmem_req_o), 32'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_req", 32'(dmem_req_o), 32'd0);
        check("mid_rst_stall", 32'(stall_o), 32'd0);
        check("mid_rst_data", Data_read_o, 32'd0);
        check("mid_rst_addr", dmem_addr_o, 32'd0);
        check("mid_rst_be", 32'(dmem_be_o), 32'd0);
        exp_dr = 32'h0;
        @(posedge clk); #1;
        check("mid_rst_hold", 32'(stall_o), 32'd0);
        rstn = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        access(1'b1, 1'b0, 3'd2, 32'h0000_3000, 32'h0, 1);
        check("post_rst_lw", Data_read_o, sw_val);

        mem[32'h4000] = 32'hCAFE_8001;
        access(1'b1, 1'b0, 3'd1, 32'h0000_4001, 32'h0, 0);
`ifdef MISALIGN_TRAP_EN
        check("tp_lh_trap", Data_read_o, sw_val);
`else
        check("tp_lh_round", Data_read_o, 32'hFFFF_8001);
`endif

        access(1'b0, 1'b0, 3'd2, 32'h0000_5000, 32'h0, 0);

        for (int n = 0; n < 120; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 4)
                access(1'b1, 1'b0, ld_f3[$urandom_range(0, 4)],
                       32'h1000 + 32'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, 3)));
            else if (kind < 7)
                access(1'b0, 1'b1, 3'($urandom_range(0, 2)),
                       32'h1000 + 32'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, 3)));
            else if (kind < 8)
                access(1'b1, 1'b1, 3'($urandom),
                       32'h1000 + 32'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, 2)));
            else if (kind < 9)
                access(1'b1, 1'b0, 3'($urandom),
                       32'h1000 + 32'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, 2)));
            else
                access(1'b0, 1'b0, 3'($urandom), $urandom, $urandom, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
